stage_mem: RTL
==============

Name: stage_mem

Overview:
- MEM stage of the five-stage pipeline CPU; sits directly downstream of the EX stage and consumes its instruction, new PC, ALU output, register B data and condition flag.
- Performs MIPS loads and stores (LW/LH/LHU/LB/LBU/SW/SH/SB) over a req/ack data-memory bus, with byte-lane steering, alignment checking and an ack timeout.
- Presents a registered MEM/WB payload to the WB stage with a valid/ready handshake, and back-pressures EX via in_ready.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in WAIT_ACK without mem_ack before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  EX payload valid
- in_ready  out  1  stage can accept the EX payload this cycle
- in_inst  in  32  instruction; opcode is in_inst[31:26]
- in_new_pc  in  32  PC+4 from EX
- in_alu_out  in  32  effective address, or ALU result
- in_reg_data_b  in  32  store data
- in_cond  in  1  branch condition from EX
- out_valid  out  1  MEM/WB payload valid
- out_ready  in  1  WB accepts the payload
- out_inst, out_new_pc, out_alu_out  out  32 each  registered pass-through of the inputs
- out_load_data  out  32  extended load result; 0 for non-loads
- out_cond  out  1  registered in_cond
- out_misalign  out  1  access was misaligned; no bus cycle was issued
- out_bus_err  out  1  access timed out
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid when mem_ack is high
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n=0 at a clock edge) clears to zero: all out_* and mem_* outputs, state=IDLE, timeout counter. Reset aborts any access in flight; mem_req is low the cycle after reset.
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. Every other opcode is a non-memory instruction.
- FSM has two states, IDLE and WAIT_ACK.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational.
- Accept = in_valid && in_ready.
- Accept of a non-memory op, or of a misaligned memory op: the output register loads on that edge and out_valid=1 next cycle (1-cycle latency).
  - out_load_data=0; out_misalign=1 only for the misaligned case.
- Alignment rule:
  - LW/SW misaligned if addr[1:0]!=0.
  - LH/LHU/SH misaligned if addr[0]!=0.
  - Byte ops are never misaligned.
- Accept of an aligned memory op: on that edge, register mem_req=1 plus stable mem_addr/mem_we/mem_be/mem_wdata; set state=WAIT_ACK; latch the payload; out_valid goes to 0 (the register was empty or consumed).
- WAIT_ACK:
  - mem_* outputs hold constant; in_ready=0.
  - The counter increments each cycle.
  - On mem_ack: mem_req=0 next cycle, the output register loads with extracted data, out_valid=1, state=IDLE.
  - mem_ack may arrive in the first mem_req cycle, giving minimum accept-to-out_valid latency of 2 cycles.
- Timeout: if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES without ack, mem_req drops, the output loads with out_bus_err=1 and out_load_data=0, and state=IDLE.
- mem_ack while mem_req=0 is ignored.
- Store lanes (little-endian, byte k = bits [8k+7:8k]):
  - SW: be=1111, wdata=B.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {B[15:0],B[15:0]}.
  - SB: be = 1<<addr[1:0]; wdata = B[7:0] replicated in all four lanes.
- Load extraction:
  - LB/LBU select the byte at lane addr[1:0]; LH/LHU select the half at addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes rdata unchanged.
  - Stores give out_load_data=0.
- Output hold: while out_valid && !out_ready, every out_* holds stable.
- Simultaneous out_ready and new accept: the old payload is consumed and the new one is captured on the same edge, sustaining 1 payload/cycle for non-memory ops.

Test Plan:
- Non-memory stream: ADD instructions on consecutive cycles, out_ready=1 -> out_valid each cycle after a 1-cycle latency; payloads in order; mem_req never asserted.
- LB at addr 0x103, mem_rdata=0x80FF_1234, ack in the first req cycle -> mem_addr=0x100, be=0000, we=0, out_load_data=0xFFFF_FF80, out_valid 2 cycles after accept; LBU -> 0x0000_0080.
- SH at addr 0x202, B=0xDEAD_BEEF, ack after 3 cycles -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1; mem_* stable and in_ready=0 until ack.
- LW at addr 0x101 -> no mem_req; out_misalign=1, out_load_data=0, 1-cycle latency.
- TIMEOUT_CYCLES=4, LW with no ack -> mem_req drops after 4 WAIT_ACK cycles; out_bus_err=1; a later ack pulse is ignored.
- Back-pressure plus reset: hold out_ready=0 with out_valid=1 -> in_ready=0 and outputs stable. Then assert rst_n=0 during WAIT_ACK -> next cycle mem_req=0, out_valid=0, state IDLE.

Source files
------------

// File: rtl/stage_mem.sv
// MEM stage: MIPS loads/stores over a req/ack data bus with lane steering,
// alignment checks and an ack timeout; registered MEM/WB output with valid/ready.
module stage_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_new_pc,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_reg_data_b,
  input  logic        in_cond,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_new_pc,
  output logic [31:0] out_alu_out,
  output logic [31:0] out_load_data,
  output logic        out_cond,
  output logic        out_misalign,
  output logic        out_bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSw  = 6'h2B;

  typedef enum logic [0:0] {StIdle, StWaitAck} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] lat_inst_q, lat_inst_d, lat_pc_q, lat_pc_d, lat_alu_q, lat_alu_d;
  logic        lat_cond_q, lat_cond_d;

  logic        out_valid_q, out_valid_d, out_cond_q, out_cond_d;
  logic        out_misalign_q, out_misalign_d, out_bus_err_q, out_bus_err_d;
  logic [31:0] out_inst_q, out_inst_d, out_new_pc_q, out_new_pc_d;
  logic [31:0] out_alu_out_q, out_alu_out_d, out_load_data_q, out_load_data_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

  logic [5:0]  in_op;
  logic        is_load, is_store, misalign, accept;

  assign in_op = in_inst[31:26];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    case (in_op)
      OpLb, OpLbu: is_load = 1'b1;
      OpLh, OpLhu: begin is_load = 1'b1;  misalign = in_alu_out[0];           end
      OpLw:        begin is_load = 1'b1;  misalign = |in_alu_out[1:0];        end
      OpSb:        is_store = 1'b1;
      OpSh:        begin is_store = 1'b1; misalign = in_alu_out[0];           end
      OpSw:        begin is_store = 1'b1; misalign = |in_alu_out[1:0];        end
      default:     ;
    endcase
  end

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Extend the addressed byte/half of the read word; non-loads yield 0.
  function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] lane,
                                          input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*lane +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OpLb:    return {{24{b[7]}}, b};
      OpLbu:   return {24'h0, b};
      OpLh:    return {{16{h[15]}}, h};
      OpLhu:   return {16'h0, h};
      OpLw:    return rdata;
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    lat_inst_d      = lat_inst_q;
    lat_pc_d        = lat_pc_q;
    lat_alu_d       = lat_alu_q;
    lat_cond_d      = lat_cond_q;
    out_valid_d     = out_valid_q;
    out_inst_d      = out_inst_q;
    out_new_pc_d    = out_new_pc_q;
    out_alu_out_d   = out_alu_out_q;
    out_load_data_d = out_load_data_q;
    out_cond_d      = out_cond_q;
    out_misalign_d  = out_misalign_q;
    out_bus_err_d   = out_bus_err_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_be_d        = mem_be_q;
    mem_wdata_d     = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if ((is_load || is_store) && !misalign) begin
            state_d     = StWaitAck;
            cnt_d       = 32'h0;
            lat_inst_d  = in_inst;
            lat_pc_d    = in_new_pc;
            lat_alu_d   = in_alu_out;
            lat_cond_d  = in_cond;
            out_valid_d = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {in_alu_out[31:2], 2'b00};
            mem_be_d    = 4'b0000;
            mem_wdata_d = 32'h0;
            case (in_op)
              OpSw: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = in_reg_data_b;
              end
              OpSh: begin
                mem_be_d    = in_alu_out[1] ? 4'b1100 : 4'b0011;
                mem_wdata_d = {2{in_reg_data_b[15:0]}};
              end
              OpSb: begin
                mem_be_d    = 4'b0001 << in_alu_out[1:0];
                mem_wdata_d = {4{in_reg_data_b[7:0]}};
              end
              default: ;
            endcase
          end else begin
            out_valid_d     = 1'b1;
            out_inst_d      = in_inst;
            out_new_pc_d    = in_new_pc;
            out_alu_out_d   = in_alu_out;
            out_cond_d      = in_cond;
            out_load_data_d = 32'h0;
            out_misalign_d  = is_load || is_store;
            out_bus_err_d   = 1'b0;
          end
        end
      end
      StWaitAck: begin
        cnt_d = cnt_q + 32'h1;
        if (mem_ack || (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1)) begin
          state_d         = StIdle;
          mem_req_d       = 1'b0;
          out_valid_d     = 1'b1;
          out_inst_d      = lat_inst_q;
          out_new_pc_d    = lat_pc_q;
          out_alu_out_d   = lat_alu_q;
          out_cond_d      = lat_cond_q;
          out_misalign_d  = 1'b0;
          out_bus_err_d   = !mem_ack;
          out_load_data_d = mem_ack ? extract(lat_inst_q[31:26], lat_alu_q[1:0], mem_rdata)
                                    : 32'h0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= 32'h0;
      lat_inst_q      <= 32'h0;
      lat_pc_q        <= 32'h0;
      lat_alu_q       <= 32'h0;
      lat_cond_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_inst_q      <= 32'h0;
      out_new_pc_q    <= 32'h0;
      out_alu_out_q   <= 32'h0;
      out_load_data_q <= 32'h0;
      out_cond_q      <= 1'b0;
      out_misalign_q  <= 1'b0;
      out_bus_err_q   <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 32'h0;
      mem_be_q        <= 4'h0;
      mem_wdata_q     <= 32'h0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      lat_inst_q      <= lat_inst_d;
      lat_pc_q        <= lat_pc_d;
      lat_alu_q       <= lat_alu_d;
      lat_cond_q      <= lat_cond_d;
      out_valid_q     <= out_valid_d;
      out_inst_q      <= out_inst_d;
      out_new_pc_q    <= out_new_pc_d;
      out_alu_out_q   <= out_alu_out_d;
      out_load_data_q <= out_load_data_d;
      out_cond_q      <= out_cond_d;
      out_misalign_q  <= out_misalign_d;
      out_bus_err_q   <= out_bus_err_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_be_q        <= mem_be_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_inst      = out_inst_q;
  assign out_new_pc    = out_new_pc_q;
  assign out_alu_out   = out_alu_out_q;
  assign out_load_data = out_load_data_q;
  assign out_cond      = out_cond_q;
  assign out_misalign  = out_misalign_q;
  assign out_bus_err   = out_bus_err_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;

endmodule
